// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX scheduler.
//   state_e : scheduler FSM state encoding (2-bit)
//   gid_w() : width of a requester index, never below 1 bit
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } state_e;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: combinational rotating-priority picker.
//   req    : request vector
//   ptr    : index of the previous winner; the scan starts at ptr+1
//   gnt    : one-hot grant (all zero when req is empty)
//   gnt_id : index of the granted requester
module uart_rr_arb #(
  parameter int N_REQ = 4,
  parameter int GID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [GID_W-1:0] gnt_id
);

  int   w_idx;
  logic w_found;

  // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the previous winner comes last.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(ptr) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = GID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among
// N_REQ byte-stream requesters, with frame locking and a lock timeout.
//   clk, reset          : system clock, async active-high reset
//   req_valid/data/last : per-requester byte offer (last=0 asks for a lock)
//   req_ready           : one-hot accept
//   tx_busy, tx_done_tick : transmitter status
//   tx_start, tx_data   : launch pulse and byte to the transmitter
//   grant_id, grant_valid : current/most recent winner, scheduler not idle
//   lock_abort          : pulse when a held lock times out
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int D_W     = 8,
  parameter int LOCK_TO = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*D_W-1:0]      req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_busy,
  input  logic                      tx_done_tick,
  output logic                      tx_start,
  output logic [D_W-1:0]            tx_data,
  output logic [gid_w(N_REQ)-1:0]   grant_id,
  output logic                      grant_valid,
  output logic                      lock_abort
);

  localparam int GID_W = gid_w(N_REQ);
  localparam int TW    = $clog2(LOCK_TO);

  state_e           r_state, w_state_nxt;
  logic [GID_W-1:0] r_ptr, r_grant_id;
  logic             r_lock;
  logic [TW-1:0]    r_timer;
  logic [D_W-1:0]   r_tx_data;

  logic [N_REQ-1:0] w_gnt, w_req_ready;
  logic [GID_W-1:0] w_gnt_id, w_sel_id;
  logic             w_idle_acc, w_hold_acc, w_timeout;

  uart_rr_arb #(.N_REQ(N_REQ), .GID_W(GID_W)) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_idle_acc  = 1'b0;
    w_hold_acc  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: if (!tx_busy && |req_valid) begin
        w_idle_acc  = 1'b1;
        w_req_ready = w_gnt;
        w_state_nxt = ST_START;
      end
      ST_START: w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_done_tick) w_state_nxt = r_lock ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        // A transfer in the timeout cycle takes precedence over the abort.
        if (req_valid[r_grant_id] && !tx_busy) begin
          w_hold_acc              = 1'b1;
          w_req_ready[r_grant_id] = 1'b1;
          w_state_nxt             = ST_START;
        end else if (r_timer == TW'(LOCK_TO - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In HOLD the locked requester is the only source; otherwise the arbiter's pick.
  assign w_sel_id = (r_state == ST_HOLD) ? r_grant_id : w_gnt_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= GID_W'(N_REQ - 1);
      r_grant_id <= '0;
      r_lock     <= 1'b0;
      r_timer    <= '0;
      r_tx_data  <= '0;
    end else begin
      if (w_idle_acc || w_hold_acc) begin
        r_tx_data <= req_data[int'(w_sel_id)*D_W +: D_W];
        r_lock    <= ~req_last[w_sel_id];
      end
      // Priority only rotates on fresh grants from IDLE.
      if (w_idle_acc) begin
        r_grant_id <= w_gnt_id;
        r_ptr      <= w_gnt_id;
      end
      if (w_timeout) r_lock <= 1'b0;
      if (r_state == ST_WAIT_DONE && tx_done_tick)
        r_timer <= '0;
      else if (r_state == ST_HOLD && !w_hold_acc && !w_timeout)
        r_timer <= r_timer + TW'(1);
    end
  end

  assign req_ready   = reset ? '0 : w_req_ready;
  assign tx_start    = (r_state == ST_START);
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign grant_valid = (r_state != ST_IDLE);
  assign lock_abort  = w_timeout;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int N = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          tx_busy = 1'b0;
  logic          tx_done_tick = 1'b0;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [1:0]    grant_id;
  logic          grant_valid;
  logic          lock_abort;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_sched #(.N_REQ(N), .D_W(DW), .LOCK_TO(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick),
    .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id),
    .grant_valid(grant_valid), .lock_abort(lock_abort)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen at +4.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sync_reset();
    reset = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done_tick = 1'b0;
    tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; #4;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    n_cmp++; if (tx_start !== 1'b0 || grant_valid !== 1'b0 || lock_abort !== 1'b0) begin n_bad++; $display("FAIL rst_ctl got start=%b gv=%b ab=%b exp 0", tx_start, grant_valid, lock_abort); end
    n_cmp++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_data got data=%h gid=%0d exp 0", tx_data, grant_id); end
    tick(); req_valid = '0; reset = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_data[7:0] = 8'h55; req_last = 4'b0001; #4;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick(); req_valid = '0; #4;
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant_id !== 2'd0) begin n_bad++; $display("FAIL single_start got st=%b d=%h g=%0d exp 1 55 0", tx_start, tx_data, grant_id); end
    tick(); tx_busy = 1'b1; #4;
    n_cmp++; if (tx_start !== 1'b0 || grant_valid !== 1'b1) begin n_bad++; $display("FAIL single_wait got st=%b gv=%b exp 0 1", tx_start, grant_valid); end
    tick(); tick(); tx_busy = 1'b0; tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0; #4;
    n_cmp++; if (grant_valid !== 1'b0 || tx_data !== 8'h55) begin n_bad++; $display("FAIL single_idle got gv=%b d=%h exp 0 55", grant_valid, tx_data); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    sync_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_last = 4'b1111; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #4;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      tick(); #4;
      n_cmp++; if (tx_start !== 1'b1 || grant_id !== 2'(k % 4) || tx_data !== 8'(8'h10 + k % 4)) begin n_bad++; $display("FAIL rr_start[%0d] got st=%b g=%0d d=%h exp g=%0d", k, tx_start, grant_id, tx_data, k % 4); end
      tick(); #4;
      n_cmp++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_wait[%0d] got st=%b rdy=%b exp 0 0000", k, tx_start, req_ready); end
      tick(); tx_done_tick = 1'b1;
      tick(); tx_done_tick = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_lock();
    sync_reset();
    req_valid = 4'b0010; req_data = {8'h00, 8'h00, 8'hA1, 8'h0F}; req_last = 4'b0001; #4;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_first got %b exp 0010", req_ready); end
    tick(); req_valid = 4'b0011;
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0;
    req_data[15:8] = 8'hA2; req_last = 4'b0011; #4;
    n_cmp++; if (req_ready !== 4'b0010 || grant_valid !== 1'b1) begin n_bad++; $display("FAIL lock_hold got rdy=%b gv=%b exp 0010 1", req_ready, grant_valid); end
    tick(); #4;
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hA2 || grant_id !== 2'd1) begin n_bad++; $display("FAIL lock_second got st=%b d=%h g=%0d exp 1 a2 1", tx_start, tx_data, grant_id); end
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0; #4;
    n_cmp++; if (req_ready !== 4'b0001 || grant_valid !== 1'b0) begin n_bad++; $display("FAIL lock_release got rdy=%b gv=%b exp 0001 0", req_ready, grant_valid); end
    tick(); req_valid = '0; #4;
    n_cmp++; if (tx_data !== 8'h0F || grant_id !== 2'd0) begin n_bad++; $display("FAIL lock_req0 got d=%h g=%0d exp 0f 0", tx_data, grant_id); end
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_timeout();
    sync_reset();
    req_valid = 4'b0100; req_data = {8'hD3, 8'hC2, 8'h00, 8'h00}; req_last = 4'b0000;
    tick(); req_valid = '0;
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0; req_valid = 4'b1000;
    // First HOLD cycle now; timer counts 0..7, abort on the eighth.
    for (int k = 0; k < 7; k++) begin
      #4;
      n_cmp++; if (lock_abort !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b1) begin n_bad++; $display("FAIL to_hold[%0d] got ab=%b rdy=%b gv=%b exp 0 0000 1", k, lock_abort, req_ready, grant_valid); end
      tick();
    end
    #4;
    n_cmp++; if (lock_abort !== 1'b1) begin n_bad++; $display("FAIL to_abort got %b exp 1", lock_abort); end
    tick(); #4;
    n_cmp++; if (lock_abort !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'b1000) begin n_bad++; $display("FAIL to_idle got ab=%b gv=%b rdy=%b exp 0 0 1000", lock_abort, grant_valid, req_ready); end
    tick(); req_valid = '0; #4;
    n_cmp++; if (tx_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'hD3) begin n_bad++; $display("FAIL to_req3 got st=%b g=%0d d=%h exp 1 3 d3", tx_start, grant_id, tx_data); end
    // req3 took a lock (last=0); transfer in the timeout cycle must win.
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    req_valid = 4'b1000; req_last = 4'b1000; req_data[31:24] = 8'hE3; #4;
    n_cmp++; if (lock_abort !== 1'b0 || req_ready !== 4'b1000) begin n_bad++; $display("FAIL to_race got ab=%b rdy=%b exp 0 1000", lock_abort, req_ready); end
    tick(); req_valid = '0; #4;
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hE3) begin n_bad++; $display("FAIL to_race_start got st=%b d=%h exp 1 e3", tx_start, tx_data); end
    tick(); tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_busy_reset();
    sync_reset();
    tx_busy = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; req_data = {8'h44, 8'h33, 8'h22, 8'h11}; #4;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL busy_ready got %b exp 0000", req_ready); end
    tick(); #4;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL busy_idle got gv=%b exp 0", grant_valid); end
    tx_busy = 1'b0;
    tick(); tick(); tx_busy = 1'b1; #4;
    n_cmp++; if (grant_valid !== 1'b1 || tx_data !== 8'h11) begin n_bad++; $display("FAIL busy_wait got gv=%b d=%h exp 1 11", grant_valid, tx_data); end
    #2; reset = 1'b1; #1;
    n_cmp++; if (grant_valid !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 || tx_start !== 1'b0 || req_ready !== 4'b0000 || lock_abort !== 1'b0) begin n_bad++; $display("FAIL async_rst got gv=%b d=%h g=%0d st=%b rdy=%b ab=%b exp all 0", grant_valid, tx_data, grant_id, tx_start, req_ready, lock_abort); end
    req_valid = '0; tx_busy = 1'b0;
    tick(); reset = 1'b0; tx_done_tick = 1'b1;
    tick(); tx_done_tick = 1'b0; #4;
    n_cmp++; if (grant_valid !== 1'b0 || tx_start !== 1'b0) begin n_bad++; $display("FAIL idle_done got gv=%b st=%b exp 0 0", grant_valid, tx_start); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_busy_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
